// File: rtl/noc_pkg.sv
// Shared NoC definitions: output port indices, flit field offsets and XY routing.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    // Destination fields are packed from the flit MSB downward: X first, then Y.
    localparam int DEST_X_OFS = 0;
    localparam int COORD_W    = 8;

    // Port index p maps to request bit NUM_PORTS-1-p, so LOCAL is the vector MSB.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input int port);
        logic [NUM_PORTS-1:0] v;
        v = '0;
        v[NUM_PORTS-1-port] = 1'b1;
        return v;
    endfunction

    function automatic logic [NUM_PORTS-1:0] xy_route(
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic [COORD_W-1:0] rx,
        input logic [COORD_W-1:0] ry
    );
        if (dx > rx)      return port_onehot(EAST);
        else if (dx < rx) return port_onehot(WEST);
        else if (dy > ry) return port_onehot(NORTH);
        else if (dy < ry) return port_onehot(SOUTH);
        else              return port_onehot(LOCAL);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular-buffer FIFO holding {route, flit} entries; pushes while full and pops while empty are ignored.
module flit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Full/empty come from the pre-edge count, so a push into a full FIFO loses even with a pop.
    assign wr_en = ce & push & ~full;
    assign rd_en = ce & pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: buffers incoming flits with a precomputed XY route and
// presents the head flit's one-hot output request to the switch allocator.
module input_port_unit
    import noc_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int X_W      = 2,
    parameter int Y_W      = 2,
    parameter int M        = 5,
    parameter int ROUTER_X = 0,
    parameter int ROUTER_Y = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_val,
    output logic              o_en,
    output logic [M-1:0]      o_output_req,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_val,
    input  logic              i_input_grant,
    output logic              o_overflow
);

    localparam int WIDTH = M + DATA_W;

    logic [X_W-1:0]   dest_x;
    logic [Y_W-1:0]   dest_y;
    logic [M-1:0]     route;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic             overflow_q, overflow_d;

    assign dest_x = i_data[DATA_W-1-DEST_X_OFS -: X_W];
    assign dest_y = i_data[DATA_W-1-DEST_X_OFS-X_W -: Y_W];
    assign route  = M'(xy_route(COORD_W'(dest_x), COORD_W'(dest_y),
                                COORD_W'(ROUTER_X), COORD_W'(ROUTER_Y)));

    flit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .push    (i_data_val),
        .pop     (i_input_grant),
        .wr_data ({route, i_data}),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_comb begin
        overflow_d = overflow_q | (ce & i_data_val & full);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) overflow_q <= 1'b0;
        else          overflow_q <= overflow_d;
    end

    // Storage is not cleared on reset, so the head is masked while empty.
    assign o_en         = ~full;
    assign o_data_val   = ~empty;
    assign o_data       = empty ? '0 : head[DATA_W-1:0];
    assign o_output_req = empty ? '0 : head[WIDTH-1 -: M];
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_input_port_unit.sv
// Scoreboard bench for input_port_unit at router (1,1): stimulus queues expected
// head flits, a negedge monitor pops and compares them whenever the DUT is granted.
module tb_input_port_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  req;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic [31:0] i_data;
    logic        i_data_val;
    logic        o_en;
    logic [4:0]  o_output_req;
    logic [31:0] o_data;
    logic        o_data_val;
    logic        i_input_grant;
    logic        o_overflow;

    exp_t exp_q[$];
    logic exp_ovf;
    int   checks;
    int   failures;

    input_port_unit #(
        .DEPTH    (DEPTH),
        .DATA_W   (32),
        .X_W      (2),
        .Y_W      (2),
        .M        (5),
        .ROUTER_X (1),
        .ROUTER_Y (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce            (ce),
        .i_data        (i_data),
        .i_data_val    (i_data_val),
        .o_en          (o_en),
        .o_output_req  (o_output_req),
        .o_data        (o_data),
        .o_data_val    (o_data_val),
        .i_input_grant (i_input_grant),
        .o_overflow    (o_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [1:0] x, input logic [1:0] y, input logic [27:0] p);
        return {x, y, p};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from the pre-edge occupancy.
    task automatic applyStimulus(input logic rst_i, input logic ce_i, input logic val,
                                 input logic [31:0] data, input logic [4:0] req, input logic grant);
        logic accept;
        logic ovf;
        reset_n       = rst_i;
        ce            = ce_i;
        i_data_val    = val;
        i_data        = data;
        i_input_grant = grant;
        accept = rst_i && ce_i && val && (exp_q.size() < DEPTH);
        ovf    = rst_i && ce_i && val && (exp_q.size() == DEPTH);
        @(posedge clk);
        #1;
        if (!rst_i) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (accept) exp_q.push_back(exp_t'{data, req});
            if (ovf) exp_ovf = 1'b1;
        end
        reset_n       = 1'b1;
        ce            = 1'b1;
        i_data_val    = 1'b0;
        i_input_grant = 1'b0;
        checkOutput("o_en", 64'(o_en), 64'(exp_q.size() != DEPTH));
        checkOutput("o_data_val", 64'(o_data_val), 64'(exp_q.size() != 0));
        checkOutput("o_overflow", 64'(o_overflow), 64'(exp_ovf));
        if (exp_q.size() == 0) begin
            checkOutput("o_output_req_empty", 64'(o_output_req), 64'd0);
            checkOutput("o_data_empty", 64'(o_data), 64'd0);
        end else begin
            checkOutput("o_output_req_head", 64'(o_output_req), 64'(exp_q[0].req));
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1, 1, 0, 32'h0, 5'b0, 1);
    endtask

    // Monitor: a granted head leaves at the next edge, so compare it against the scoreboard now.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && ce && i_input_grant && (o_data_val || exp_q.size() > 0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL pop_unexpected: got data %0h req %b expected no flit", o_data, o_output_req);
            end else begin
                e = exp_q.pop_front();
                if (!o_data_val || o_data !== e.data || o_output_req !== e.req) begin
                    failures++;
                    $display("[TB] FAIL pop_flit: got val %0b data %0h req %b expected data %0h req %b",
                             o_data_val, o_data, o_output_req, e.data, e.req);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] req_by_x [4];
        req_by_x[0] = 5'b00001;
        req_by_x[1] = 5'b10000;
        req_by_x[2] = 5'b00100;
        req_by_x[3] = 5'b00100;

        clk = 0; reset_n = 0; ce = 1; i_data = '0; i_data_val = 0; i_input_grant = 0;
        exp_ovf = 0; checks = 0; failures = 0;

        // Reset held two cycles
        applyStimulus(0, 1, 0, 32'h0, 5'b0, 0);
        applyStimulus(0, 1, 0, 32'h0, 5'b0, 0);
        applyStimulus(1, 1, 0, 32'h0, 5'b0, 0);

        // Latency: no combinational bypass from i_data_val
        i_data_val = 1; i_data = mk(2'd1, 2'd1, 28'h000_0AA);
        #1;
        checkOutput("no_bypass_val", 64'(o_data_val), 64'd0);
        checkOutput("no_bypass_req", 64'(o_output_req), 64'd0);
        applyStimulus(1, 1, 1, mk(2'd1, 2'd1, 28'h000_0AA), 5'b10000, 0);
        applyStimulus(1, 1, 0, 32'h0, 5'b0, 1);

        // Routing from router (1,1)
        applyStimulus(1, 1, 1, mk(2'd3, 2'd1, 28'h000_0001), 5'b00100, 0);
        applyStimulus(1, 1, 1, mk(2'd0, 2'd2, 28'h000_0002), 5'b00001, 0);
        applyStimulus(1, 1, 1, mk(2'd1, 2'd2, 28'h000_0003), 5'b01000, 0);
        applyStimulus(1, 1, 1, mk(2'd1, 2'd0, 28'h000_0004), 5'b00010, 0);
        drain(1);
        applyStimulus(1, 1, 1, mk(2'd1, 2'd1, 28'h000_0005), 5'b10000, 0);
        drain(4);

        // Simultaneous push/pop at occupancy 2 across pointer wrap
        applyStimulus(1, 1, 1, mk(2'd0, 2'd1, 28'h100_0000), req_by_x[0], 0);
        applyStimulus(1, 1, 1, mk(2'd1, 2'd1, 28'h100_0001), req_by_x[1], 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 1, mk(2'(i % 4), 2'd1, 28'h200_0000 + 28'(i)), req_by_x[i % 4], 1);
            checkOutput("pushpop_count", 64'(exp_q.size()), 64'd2);
        end
        drain(2);

        // Fill, then overflow: the fifth flit must be dropped
        applyStimulus(1, 1, 1, mk(2'd2, 2'd0, 28'h300_0000), 5'b00100, 0);
        applyStimulus(1, 1, 1, mk(2'd1, 2'd3, 28'h300_0001), 5'b01000, 0);
        applyStimulus(1, 1, 1, mk(2'd0, 2'd0, 28'h300_0002), 5'b00001, 0);
        applyStimulus(1, 1, 1, mk(2'd1, 2'd0, 28'h300_0003), 5'b00010, 0);
        checkOutput("full_o_en", 64'(o_en), 64'd0);
        applyStimulus(1, 1, 1, mk(2'd3, 2'd3, 28'h300_0004), 5'b00100, 0);
        checkOutput("overflow_set", 64'(o_overflow), 64'd1);
        // Full with push+pop: read proceeds, write rejected
        applyStimulus(1, 1, 1, mk(2'd3, 2'd3, 28'h300_0005), 5'b00100, 1);
        drain(3);

        // Clock enable low freezes everything, then reset with ce low empties the FIFO
        applyStimulus(1, 1, 1, mk(2'd2, 2'd2, 28'h400_0000), 5'b00100, 0);
        applyStimulus(1, 1, 1, mk(2'd1, 2'd2, 28'h400_0001), 5'b01000, 0);
        applyStimulus(1, 1, 1, mk(2'd0, 2'd3, 28'h400_0002), 5'b00001, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, mk(2'd3, 2'd0, 28'h500_0000), 5'b00100, 1);
            checkOutput("ce0_head_data", 64'(o_data), 64'(mk(2'd2, 2'd2, 28'h400_0000)));
        end
        applyStimulus(0, 0, 0, 32'h0, 5'b0, 0);
        checkOutput("reset_ce0_empty", 64'(o_data_val), 64'd0);
        checkOutput("reset_clears_ovf", 64'(o_overflow), 64'd0);
        applyStimulus(1, 1, 0, 32'h0, 5'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
